// File: rtl/pkt_rd_streamer.sv
// pkt_rd_streamer: per-port SRAM read streamer with a credit-gated return buffer.
// Define PKT_RD_CNT_EN to add the 16-bit pkt_cnt transmitted-packet counter.
module pkt_rd_streamer #(
  parameter int data_width        = 64,
  parameter int address_width     = 17,
  parameter int pack_length_width = 8,
  parameter int buf_depth         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         desc_vld,
  input  logic [address_width-1:0]     desc_addr,
  input  logic [pack_length_width-1:0] desc_len,
  output logic                         desc_rdy,
  output logic                         rd_req,
  output logic [address_width-1:0]     rd_addr,
  input  logic                         rd_gnt,
  input  logic [data_width-1:0]        sram_dout,
  input  logic                         ready,
  output logic                         rd_sop,
  output logic                         rd_eop,
  output logic                         rd_vld,
  output logic [data_width-1:0]        rd_data,
  output logic                         busy
`ifdef PKT_RD_CNT_EN
  ,
  output logic [15:0]                  pkt_cnt
`endif
);

  localparam int LW = pack_length_width + 1;
  localparam int PW = (buf_depth > 1) ? $clog2(buf_depth) : 1;
  localparam int CW = $clog2(buf_depth + 1) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     req_q, req_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [LW-1:0]            req_left_q, req_left_d;
  logic [LW-1:0]            beat_left_q, len_ext;
  logic                     inflight_q, first_q;
  logic [CW-1:0]            cnt_q, cnt_n;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [data_width-1:0]    mem [buf_depth];
  logic                     accept, grant, push, pop;
  logic                     last_beat, room;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(buf_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign len_ext   = {desc_len == '0, desc_len};
  assign desc_rdy  = rst & (state_q == IDLE);
  assign busy      = state_q != IDLE;
  assign accept    = desc_vld & desc_rdy;
  assign grant     = req_q & rd_gnt;
  assign push      = inflight_q;
  assign rd_vld    = cnt_q != '0;
  assign pop       = rd_vld & ready;
  assign last_beat = beat_left_q == LW'(1);
  assign cnt_n     = cnt_q + CW'(push) - CW'(pop);
  // Credit seen by the next request: buffered words plus the one granted now.
  assign room      = (cnt_n + CW'(grant)) < CW'(buf_depth);

  assign rd_req  = req_q;
  assign rd_addr = addr_q;
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign rd_sop  = rd_vld & first_q;
  assign rd_eop  = rd_vld & last_beat;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_d    = FETCH;
          req_d      = 1'b1;
          addr_d     = desc_addr;
          req_left_d = len_ext;
        end
      end
      (state_q == FETCH): begin
        if (grant) begin
          addr_d     = addr_q + address_width'(1);
          req_left_d = req_left_q - LW'(1);
          if (req_left_q == LW'(1)) begin
            state_d = DRAIN;
            req_d   = 1'b0;
          end else begin
            req_d = room;
          end
        end else if (!req_q) begin
          req_d = room;
        end
      end
      (state_q == DRAIN): begin
        if (pop && last_beat) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      req_left_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q  <= 1'b0;
      cnt_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat_left_q <= '0;
      first_q     <= 1'b0;
    end else begin
      inflight_q <= grant;
      cnt_q      <= cnt_n;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (accept) begin
        beat_left_q <= len_ext;
        first_q     <= 1'b1;
      end else if (pop) begin
        beat_left_q <= beat_left_q - LW'(1);
        first_q     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sram_dout;
  end

`ifdef PKT_RD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pkt_cnt <= '0;
    else if (pop && last_beat) pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/pkt_rd_streamer.md
Name: pkt_rd_streamer

Overview:
- Per-output-port read-side streamer; the read counterpart of the write-side segmenter that stores packets into the shared SRAM.
- Accepts one packet descriptor (start address, length) from the cache manager and arbitrates for the SRAM read port through `rd_req`/`rd_gnt`.
- Absorbs the 1-cycle SRAM read latency in a small credit-managed buffer.
- Emits the packet on the egress interface (`rd_sop`/`rd_vld`/`rd_eop`/`rd_data`) under downstream `ready` backpressure.

Parameters:
- `data_width`, 64, SRAM word and egress data width.
- `address_width`, 17, SRAM address width.
- `pack_length_width`, 8, descriptor length field width (words).
- `buf_depth`, 4, return buffer entries; must be ≥3 for full rate, ≥2 legal.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset: asynchronous assert, active-low; synchronous deassert is handled externally.
- `desc_vld`  in  1  descriptor available.
- `desc_addr`  in  address_width  first word address.
- `desc_len`  in  pack_length_width  packet length in words; 0 encodes 2^pack_length_width.
- `desc_rdy`  out  1  descriptor accepted when `desc_vld & desc_rdy`.
- `rd_req`  out  1  SRAM read-port request.
- `rd_addr`  out  address_width  read address, valid while `rd_req`.
- `rd_gnt`  in  1  read port granted this cycle.
- `sram_dout`  in  data_width  SRAM `doutb`, valid 1 cycle after `rd_req & rd_gnt`.
- `ready`  in  1  downstream accepts the beat.
- `rd_sop`  out  1  first beat of the packet.
- `rd_eop`  out  1  last beat of the packet.
- `rd_vld`  out  1  beat valid.
- `rd_data`  out  data_width  beat data.
- `busy`  out  1  packet in progress (state ≠ IDLE).

Behaviour:
- Reset values: all outputs 0 (`desc_rdy` 0 during reset); FSM→IDLE; buffer empty; in-flight flag 0; counters 0.
- FSM IDLE:
  - `desc_rdy` = 1.
  - On `desc_vld`: latch addr→`cur_addr`, len→`req_left` and `beat_left` (0 → 2^width).
  - Go to FETCH.
- FSM FETCH:
  - `rd_req` = 1 when credit > 0, where credit = `buf_depth` − `buf_count` − `inflight`.
  - `rd_req`/`rd_addr` are registered and held stable until granted.
  - On `rd_req & rd_gnt`: `cur_addr`+1 (wraps modulo 2^address_width); `req_left`−1; set in-flight.
  - When the last request is granted: go to DRAIN; `rd_req` is 0 the next cycle.
- FSM DRAIN: no requests. When the beat with `rd_eop` transfers, go to IDLE.
- `rd_gnt` without `rd_req` is ignored.
- Return path:
  - The in-flight flag clears one cycle after grant; `sram_dout` is written into the buffer at that edge.
  - `sram_dout` is never sampled unless the in-flight flag is set.
- Egress:
  - `rd_vld` = buffer non-empty; `rd_data` = buffer head.
  - Transfer when `rd_vld & ready`.
  - `rd_data`/`rd_sop`/`rd_eop` stay stable while `rd_vld & !ready`.
- Beat flags:
  - `rd_sop` is 1 on the first beat after descriptor accept.
  - `rd_eop` is 1 when `beat_left` == 1; a 1-word packet has sop and eop together.
  - `beat_left` decrements per transfer.
- Latency: descriptor accept at cycle 0 → `rd_req` cycle 1 → (immediate grant) data in buffer at cycle 2 → `rd_vld` cycle 3.
- Throughput: with `ready` and `rd_gnt` held 1 and `buf_depth` ≥ 3, one beat per cycle.
- Simultaneous buffer write and read in the same cycle: `buf_count` unchanged. The buffer never overflows, because requests are credit-gated.
- Back-to-back packets: the next descriptor is accepted only in IDLE, giving a 1-cycle gap minimum from eop transfer to `desc_rdy`.
- Reset mid-packet: everything cleared immediately; the SRAM return after deassert is discarded (in-flight = 0); no partial eop is generated.

Optional Feature:
- Macro: `PKT_RD_CNT_EN`.
- Defined: adds output port `pkt_cnt` [15:0].
  - +1 on every `rd_eop & rd_vld & ready`; wraps 0xFFFF→0; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Len 4, addr 0x00010, `rd_gnt`=1, `ready`=1 → `rd_addr` 0x10..0x13 on cycles 1-4; `rd_vld` cycles 3-6; sop at cycle 3, eop at cycle 6; `busy` falls at cycle 7.
- Len 1, addr 0x1FFFF → single beat with sop=eop=1, data = SRAM word at 0x1FFFF; a len 3 packet from 0x1FFFF reads 0x1FFFF, 0x00000, 0x00001.
- Len 8, `ready` low for cycles 4-9 → `rd_req` stops once credit = 0 (never more than 4 words buffered plus in flight); data order is preserved; `rd_data` held stable while stalled; 8 beats total.
- Len 5, `rd_gnt` pulsed every 3rd cycle → `rd_addr` held until granted; 5 beats in address order with no duplicates.
- `desc_len`=0 → exactly 256 beats, eop on beat 256; reset asserted mid-packet (beat 100) → outputs 0 immediately; after release `desc_rdy`=1 and no stray beat appears.
- `PKT_RD_CNT_EN`: three packets of len 2 → `pkt_cnt`=3; preload near wrap → 0xFFFF→0x0000.
